// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button level in, debounced level and busy out.
// The master drives btn_in; the debouncer is the slave.
interface button_debouncer_if;
    logic btn_in;
    logic btn_out;
    logic busy;

    modport master (
        output btn_in,
        input  btn_out,
        input  busy
    );

    modport slave (
        input  btn_in,
        output btn_out,
        output busy
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizer + 4-state Moore FSM with stability counter.
// BUTTON_DEBOUNCER_SYNC_EN adds the two-flop input synchronizer.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input logic              clk,
    input logic              rst,
    button_debouncer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [23:0] TERM = 24'(STABLE_CYCLES - 1);

    state_t      state;
    state_t      state_d;
    logic [23:0] cnt;
    logic [23:0] cnt_d;
    logic        out_q;
    logic        out_d;
    logic        btn_s;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.btn_in};
        end
    end

    assign btn_s = sync_q[1];
`else
    assign btn_s = bus.btn_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE_LO;
            cnt   <= '0;
            out_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            out_q <= out_d;
        end
    end

    // A reversal beats the terminal count: the glitch test comes first.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE_LO: begin
                if (btn_s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!btn_s) begin
                    state_d = IDLE_LO;
                end else if (cnt == TERM) begin
                    state_d = IDLE_HI;
                end else begin
                    cnt_d = cnt + 24'd1;
                end
            end
            IDLE_HI: begin
                if (!btn_s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (btn_s) begin
                    state_d = IDLE_HI;
                end else if (cnt == TERM) begin
                    state_d = IDLE_LO;
                end else begin
                    cnt_d = cnt + 24'd1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
        out_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    end

    assign bus.btn_out = out_q;
    assign bus.busy    = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard of per-edge expected btn_out/busy from a
// run-length model of the qualification rule, plus directed latency checks.
module tb_button_debouncer;

    localparam int SC = 4;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    localparam int LAT = SC + SD;

    logic clk = 1'b0;
    logic rst = 1'b0;

    button_debouncer_if bus ();

    button_debouncer #(
        .STABLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int rises  = 0;

    logic [1:0] q[$];
    logic       m_s1 = 1'b0;
    logic       m_s2 = 1'b0;
    logic       m_out = 1'b0;
    int         m_run = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    // Model: out flips once the (delayed) input differs for SC+1 edges.
    always @(posedge clk) begin
        logic v;
        if (!rst) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_out = 1'b0;
            m_run = 0;
        end else begin
            v = (SD == 2) ? m_s2 : bus.btn_in;
            m_s2 = m_s1;
            m_s1 = bus.btn_in;
            if (v != m_out) begin
                m_run++;
                if (m_run == SC + 1) begin
                    m_out = v;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        q.push_back({m_out, m_run != 0});
    end

    always @(negedge rst) q.delete();

    always @(negedge clk) begin
        logic [1:0] e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_out", int'(bus.btn_out), int'(e[1]));
            chk("sb_busy", int'(bus.busy), int'(e[0]));
        end
    end

    always @(posedge bus.btn_out) rises++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edge index (0 = first edge after call) at which btn_out reaches lvl.
    task automatic wait_lvl(input string tag, input logic lvl, input int exp);
        int k;
        k = -1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (bus.btn_out == lvl) begin
                k = i;
                break;
            end
        end
        chk(tag, k, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 want 1");
        $fatal(1);
    end

    initial begin
        bus.btn_in = 1'b1;
        rst = 1'b0;
        tick(3);
        chk("rst_out", int'(bus.btn_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rises = 0;
        rst = 1'b1;
        wait_lvl("s1_lat", 1'b1, LAT);
        tick(6);
        chk("s1_rises", rises, 1);

        bus.btn_in = 1'b0;
        wait_lvl("s2_fall", 1'b0, LAT);
        tick(3);
        rises = 0;
        bus.btn_in = 1'b1;
        wait_lvl("s2_rise", 1'b1, LAT);
        tick(20);
        chk("s2_rises", rises, 1);
        chk("s2_busy", int'(bus.busy), 0);

        bus.btn_in = 1'b0;
        wait_lvl("s3_fall0", 1'b0, LAT);
        tick(3);
        bus.btn_in = 1'b1;
        tick(3);
        bus.btn_in = 1'b0;
        tick(10);
        chk("s3_out", int'(bus.btn_out), 0);
        chk("s3_busy", int'(bus.busy), 0);
        bus.btn_in = 1'b1;
        wait_lvl("s3_rise", 1'b1, LAT);
        tick(3);

        bus.btn_in = 1'b0;
        wait_lvl("s4_fall0", 1'b0, LAT);
        tick(3);
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            bus.btn_in = (i % 2 == 0);
            tick(2);
        end
        bus.btn_in = 1'b1;
        wait_lvl("s4_rise", 1'b1, LAT);
        tick(4);
        chk("s4_rises", rises, 1);
        bus.btn_in = 1'b0;
        wait_lvl("s4_fall", 1'b0, LAT);
        tick(2);

        bus.btn_in = 1'b1;
        repeat (SD + 3) @(posedge clk);
        #1;
        chk("s5_busy_pre", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk("s5_rst_out", int'(bus.btn_out), 0);
        chk("s5_rst_busy", int'(bus.busy), 0);
        tick(2);
        rst = 1'b1;
        wait_lvl("s5_lat", 1'b1, LAT);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
